instr_dec_queue: RTL

//  Parametrised, buffered successor to the combinational instruction decoder.

---
 rtl/instr_dec_queue.sv | 134 +++++++++++++
 1 files changed

// File: rtl/instr_dec_queue.sv
// Buffered instruction decoder: a DEPTH-entry FIFO feeding one registered decode stage.
// Define DEC_ILLEGAL_EN to register an illegal-opcode flag alongside the decode stage.
module instr_dec_queue #(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 4,
   parameter int REG_AW = 3
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [15:0]              in_instr,
   input  logic                     flush,
   output logic                     out_valid,
   input  logic                     out_ready,
   input  logic [2:0]               nsel,
   output logic [2:0]               opcode,
   output logic [1:0]               op,
   output logic [1:0]               ALUop,
   output logic [1:0]               shift,
   output logic [REG_AW-1:0]        readnum,
   output logic [REG_AW-1:0]        writenum,
   output logic [DATA_W-1:0]        sximm5,
   output logic [DATA_W-1:0]        sximm8,
   output logic                     nsel_err,
   output logic                     illegal,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [15:0]       r_mem [DEPTH];
   logic [PW-1:0]     r_wptr;
   logic [PW-1:0]     r_rptr;
   logic [CW-1:0]     r_count;
   logic              r_out_valid;
   logic [15:0]       r_instr;

   logic              w_push;
   logic              w_load;
   logic              w_pop;
   logic              w_bypass;
   logic              w_wr;
   logic [15:0]       w_next;
   logic [REG_AW-1:0] w_regnum;
   logic              w_nsel_err;

   assign in_ready = (r_count < CW'(DEPTH));
   assign w_push   = in_valid & in_ready;
   assign w_load   = ~r_out_valid | out_ready;
   assign w_pop    = w_load & (r_count != '0);
   // An empty queue hands the incoming word straight to the decode stage.
   assign w_bypass = w_load & (r_count == '0) & w_push;
   assign w_wr     = w_push & ~w_bypass;
   assign w_next   = w_pop ? r_mem[r_rptr] : in_instr;

   always_ff @(posedge clk) begin
      if (w_wr && !flush)
         r_mem[r_wptr] <= in_instr;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wptr      <= '0;
         r_rptr      <= '0;
         r_count     <= '0;
         r_out_valid <= 1'b0;
      end else if (flush) begin
         r_wptr      <= '0;
         r_rptr      <= '0;
         r_count     <= '0;
         r_out_valid <= 1'b0;
      end else begin
         if (w_wr)
            r_wptr <= r_wptr + PW'(1);
         if (w_pop)
            r_rptr <= r_rptr + PW'(1);
         r_count <= r_count + CW'(w_wr) - CW'(w_pop);
         if (w_load)
            r_out_valid <= w_pop | w_bypass;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         r_instr <= '0;
      else if (!flush && (w_pop || w_bypass))
         r_instr <= w_next;
   end

`ifdef DEC_ILLEGAL_EN
   logic r_illegal;

   function automatic logic f_illegal(input logic [15:0] i);
      return (i[15:13] < 3'b011) || (i[15:13] == 3'b110 && i[12:11] == 2'b01);
   endfunction

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         r_illegal <= 1'b0;
      else if (!flush && (w_pop || w_bypass))
         r_illegal <= f_illegal(w_next);
   end

   assign illegal = r_illegal;
`else
   assign illegal = 1'b0;
`endif

   always_comb begin
      w_regnum   = '0;
      w_nsel_err = 1'b0;
      case (nsel)
         3'b001:  w_regnum = REG_AW'(r_instr[10:8]);
         3'b010:  w_regnum = REG_AW'(r_instr[7:5]);
         3'b100:  w_regnum = REG_AW'(r_instr[2:0]);
         default: w_nsel_err = 1'b1;
      endcase
   end

   assign out_valid = r_out_valid;
   assign count     = r_count;
   assign opcode    = r_instr[15:13];
   assign op        = r_instr[12:11];
   assign ALUop     = r_instr[12:11];
   assign shift     = r_instr[4:3];
   assign readnum   = w_regnum;
   assign writenum  = w_regnum;
   assign nsel_err  = w_nsel_err;
   assign sximm5    = {{(DATA_W-5){r_instr[4]}}, r_instr[4:0]};
   assign sximm8    = {{(DATA_W-8){r_instr[7]}}, r_instr[7:0]};

endmodule
